wfm_trig_reader: RTL and testbench

- Reader end of the waveform delay path. Consumes the delayed waveform word stream that the delay chain produces every clock.
- On a trigger pulse, writes a window of consecutive words into an internal circular buffer.
- Streams the captured window out over a valid/ready interface toward readout/DMA logic.
- Capture and drain overlap: reading starts as soon as word 0 is stored, and the read side never passes the write side.

---
 rtl/wfm_trig_reader_pkg.sv | 23 ++
 rtl/wfm_buf_ram.sv | 37 +++
 rtl/wfm_trig_reader.sv | 193 +++++++++++++++++++
 tb/tb_wfm_trig_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wfm_trig_reader_pkg.sv
// Shared types and helpers for the triggered waveform reader.
package wfm_trig_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  function automatic int unsigned depth_of(input int unsigned log2);
    return 32'd1 << log2;
  endfunction

  // Zero-length requests still capture one word; oversize ones fill the buffer.
  function automatic int unsigned clamp_len(input int unsigned n, input int unsigned depth);
    if (n == 0) return 1;
    if (n > depth) return depth;
    return n;
  endfunction

endpackage

// File: rtl/wfm_buf_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// The read register only updates on rd_en, so it holds its word under backpressure.
module wfm_buf_ram #(
  parameter int BITS       = 56,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [BITS-1:0]       wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [BITS-1:0]       rd_data
);

  logic [BITS-1:0] mem [2**DEPTH_LOG2];
  logic [BITS-1:0] rd_data_q;
  logic [BITS-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wfm_trig_reader.sv
// Trigger-driven window capture of the delayed waveform stream, drained over valid/ready.
// Optional header beat with trigger timestamp when WFM_TRIG_READER_HEADER_EN is defined.
module wfm_trig_reader
  import wfm_trig_reader_pkg::*;
#(
  parameter int BITS       = 56,
  parameter int DEPTH_LOG2 = 6,
  parameter int TS_BITS    = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS-1:0]       d_in,
  input  logic                  trig,
  input  logic [DEPTH_LOG2:0]   n_words,
  output logic [BITS-1:0]       out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           trig_dropped
);

  localparam int unsigned DEPTH = depth_of(DEPTH_LOG2);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef WFM_TRIG_READER_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   n_q, n_d;
  logic            out_vld_q, out_vld_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic            hdr_sel_q, hdr_sel_d;
  logic            hdr_pend_q, hdr_pend_d;
  logic [15:0]     drop_q, drop_d;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic                  rd_en;
  logic                  can_load;
  logic [BITS-1:0]       ram_q;
  logic [BITS-1:0]       hdr_word;
  logic [TS_BITS-1:0]    ts_lat;

`ifdef WFM_TRIG_READER_HEADER_EN
  logic [TS_BITS-1:0] ts_q, ts_d, ts_lat_q, ts_lat_d;

  always_comb begin
    ts_d     = ts_q + TS_BITS'(1);
    ts_lat_d = ts_lat_q;
    if (state_q == ST_IDLE && trig) ts_lat_d = ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
    end
  end

  assign ts_lat = ts_lat_q;
`else
  assign ts_lat = '0;
`endif

  always_comb begin
    hdr_word                 = '0;
    hdr_word[TS_BITS-1:0]    = ts_lat;
    hdr_word[BITS-1 -: 8]    = HDR_TAG;
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    n_d        = n_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    hdr_sel_d  = hdr_sel_q;
    hdr_pend_d = hdr_pend_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt_q[DEPTH_LOG2-1:0];
    rd_en      = 1'b0;
    // The RAM read register doubles as the output stage; refill when empty or accepted.
    can_load   = !out_vld_q || out_ready;

    if (out_vld_q && out_ready) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      hdr_sel_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          wr_cnt_d   = ONE;
          rd_ptr_d   = '0;
          n_d        = CW'(clamp_len(32'(n_words), DEPTH));
          hdr_pend_d = HDR_EN;
          state_d    = ST_RUN;
        end
      end
      ST_RUN, ST_FLUSH: begin
        if (trig && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

        if (wr_cnt_q < n_q) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + ONE;
        end
        if (state_q == ST_RUN && wr_cnt_d == n_q) state_d = ST_FLUSH;

        if (can_load) begin
          if (hdr_pend_q) begin
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            hdr_sel_d  = 1'b1;
            hdr_pend_d = 1'b0;
          end else if (rd_ptr_q < wr_cnt_q) begin
            rd_en      = 1'b1;
            rd_ptr_d   = rd_ptr_q + ONE;
            out_vld_d  = 1'b1;
            out_last_d = (rd_ptr_q == n_q - ONE);
            hdr_sel_d  = 1'b0;
          end
        end

        if (state_q == ST_FLUSH && out_vld_q && out_ready && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      n_q        <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      hdr_sel_q  <= 1'b0;
      hdr_pend_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      n_q        <= n_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      busy_q     <= busy_d;
      hdr_sel_q  <= hdr_sel_d;
      hdr_pend_q <= hdr_pend_d;
      drop_q     <= drop_d;
    end
  end

  wfm_buf_ram #(
    .BITS       (BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (d_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data (ram_q)
  );

  assign out_data     = hdr_sel_q ? hdr_word : ram_q;
  assign out_valid    = out_vld_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign trig_dropped = drop_q;

endmodule

// File: tb/tb_wfm_trig_reader.sv
// Scoreboard bench for wfm_trig_reader: windows pushed at trigger, popped on each handshake.
module tb_wfm_trig_reader;

  localparam int BITS = 56;
`ifdef WFM_TRIG_READER_HEADER_EN
  localparam int HL = 1;
`else
  localparam int HL = 0;
`endif

  typedef struct packed {
    logic [BITS-1:0] d;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [BITS-1:0] d_in = '0;
  logic            trig = 1'b0;
  logic [6:0]      n_words = '0;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic            busy;
  logic [15:0]     trig_dropped;

  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              hs_cnt = 0;
  logic            rdy_toggle = 1'b0;
  logic            stall_prev = 1'b0;
  logic [BITS-1:0] held_d = '0;
  logic            held_l = 1'b0;

`ifdef WFM_TRIG_READER_HEADER_EN
  logic [47:0] ts_m = '0;
  always @(posedge clk) ts_m <= reset ? 48'd0 : ts_m + 48'd1;
`endif

  wfm_trig_reader dut (
    .clk          (clk),
    .reset        (reset),
    .d_in         (d_in),
    .trig         (trig),
    .n_words      (n_words),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .trig_dropped (trig_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    d_in = d_in + 1'b1;
    out_ready = rdy_toggle ? ~out_ready : 1'b1;
  endtask

  // Drive one trigger cycle and record the window the DUT must produce.
  task automatic start(input logic [6:0] n);
    int   neff;
    exp_t e;
    neff = (n == 0) ? 1 : (n > 64) ? 64 : int'(n);
    trig = 1'b1;
    n_words = n;
`ifdef WFM_TRIG_READER_HEADER_EN
    e.d = '0;
    e.d[47:0] = ts_m;
    e.d[55:48] = 8'hA5;
    e.last = 1'b0;
    exp_q.push_back(e);
`endif
    for (int k = 0; k < neff; k++) begin
      e.d = d_in + BITS'(k);
      e.last = (k == neff - 1);
      exp_q.push_back(e);
    end
    step();
    trig = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while ((busy || exp_q.size() != 0) && i < limit) begin
      step();
      i++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", 64'(out_valid), 64'd1);
        chk("hold_dat", 64'(out_data), 64'(held_d));
        chk("hold_last", 64'(out_last), 64'(held_l));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("data", 64'(out_data), 64'(e.d));
          chk("last", 64'(out_last), 64'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end
  end

  initial begin
    int k;
    int hs0;

    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(trig_dropped), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    repeat (7) step();

    // Basic window, full throughput
    hs0 = hs_cnt;
    start(7'd8);
    chk("t1_busy_rise", 64'(busy), 64'd1);
    chk("t1_vld_early", 64'(out_valid), 64'd0);
    step();
    chk("t1_vld_first", 64'(out_valid), 64'd1);
    k = 2;
    while (busy && k < 100) begin
      step();
      k++;
    end
    chk("t1_busy_fall", 64'(k), 64'(10 + HL));
    wait_done(100);
    chk("t1_beats", 64'(hs_cnt - hs0), 64'(8 + HL));

    // Toggling backpressure
    rdy_toggle = 1'b1;
    hs0 = hs_cnt;
    start(7'd8);
    wait_done(200);
    chk("t2_beats", 64'(hs_cnt - hs0), 64'(8 + HL));
    rdy_toggle = 1'b0;
    step();

    // Length clamps
    hs0 = hs_cnt;
    start(7'd0);
    wait_done(100);
    chk("t3_len0", 64'(hs_cnt - hs0), 64'(1 + HL));
    hs0 = hs_cnt;
    start(7'd100);
    wait_done(300);
    chk("t3_len100", 64'(hs_cnt - hs0), 64'(64 + HL));

    // Dropped triggers: one mid-window, one coincident with the last handshake
    hs0 = hs_cnt;
    start(7'd8);
    repeat (2) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (5 + HL) step();
    chk("t4_last_vis", 64'(out_valid && out_last), 64'd1);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_done(100);
    repeat (3) step();
    chk("t4_dropped", 64'(trig_dropped), 64'd2);
    chk("t4_beats", 64'(hs_cnt - hs0), 64'(8 + HL));
    chk("t4_idle", 64'(busy), 64'd0);

    // Reset in the middle of a window, then a fresh window
    hs0 = hs_cnt;
    start(7'd8);
    k = 0;
    while (hs_cnt - hs0 < 4 + HL && k < 100) begin
      step();
      k++;
    end
    chk("t5_reached", 64'(hs_cnt - hs0 >= 4 + HL), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("t5_rst_vld", 64'(out_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_drop", 64'(trig_dropped), 64'd0);
    reset = 1'b0;
    step();
    hs0 = hs_cnt;
    start(7'd5);
    wait_done(100);
    chk("t5_beats", 64'(hs_cnt - hs0), 64'(5 + HL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
